// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the framed-UART receiver: FSM states, drop reasons
// and the CRC-32/ISO-HDLC constants.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_OPT   = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSM   = 3'd4,
    ST_CHECK = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_LINE    = 3'd4;

  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  localparam int CSM_BYTES = 4;

endpackage

// File: rtl/uart_frame_rx_crc32_byte.sv
// Reflected CRC-32 register advanced by one whole byte per enabled cycle.
// The output is the raw register; the caller applies the final xor.
module crc32_byte
  import uart_frame_rx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         init,
  input  logic         en,
  input  logic [W-1:0] in_byte,
  output logic [31:0]  crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] step;

  always_comb begin
    step = crc_q;
    // LSB-first bit loop: the reflected form consumes byte bit 0 first.
    for (int i = 0; i < W; i++) begin
      step = (step[0] ^ in_byte[i]) ? ((step >> 1) ^ CRC_POLY) : (step >> 1);
    end
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = step;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind a byte UART: SYNC, option, length, payload, optional
// CRC-32 trailer. Reports a good frame or the reason a frame was dropped.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int                   BYTE_SIZE   = 8,
  parameter int                   MAX_LEN     = 16,
  parameter logic [BYTE_SIZE-1:0] SYNC_BYTE   = 8'h7E,
  parameter bit                   CSM_EN      = 1'b1,
  parameter int                   TIMEOUT_CYC = 100000
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           in_valid,
  input  logic [BYTE_SIZE-1:0]           in_data,
  input  logic                           in_err,
  output logic [BYTE_SIZE-1:0]           o_opt,
  output logic [BYTE_SIZE-1:0]           o_len,
  output logic [MAX_LEN*BYTE_SIZE-1:0]   o_data,
  output logic                           o_valid,
  output logic                           o_err,
  output logic [2:0]                     o_err_code
);

  localparam int                   BUF_W     = MAX_LEN * BYTE_SIZE;
  localparam int                   TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BYTE_SIZE-1:0] MAX_LEN_B = BYTE_SIZE'(MAX_LEN);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]           CSM_LAST  = 2'(CSM_BYTES - 1);

  state_e                 state_q,     state_d;
  logic [BYTE_SIZE-1:0]   opt_q,       opt_d;
  logic [BYTE_SIZE-1:0]   len_q,       len_d;
  logic [BYTE_SIZE-1:0]   cnt_q,       cnt_d;
  logic [BUF_W-1:0]       buf_q,       buf_d;
  logic [23:0]            csm_q,       csm_d;
  logic [1:0]             csm_cnt_q,   csm_cnt_d;
  logic [TMO_W-1:0]       tmo_q,       tmo_d;
  logic [BYTE_SIZE-1:0]   o_opt_q,     o_opt_d;
  logic [BYTE_SIZE-1:0]   o_len_q,     o_len_d;
  logic [BUF_W-1:0]       o_data_q,    o_data_d;
  logic                   o_valid_q,   o_valid_d;
  logic                   o_err_q,     o_err_d;
  logic [2:0]             o_err_code_q, o_err_code_d;

  logic             crc_init;
  logic             crc_en;
  logic [31:0]      crc_val;
  logic [BUF_W-1:0] buf_wr;
  logic             crc_ok;
  logic             tmo_hit;

  crc32_byte #(.W(8)) u_crc (
    .CLK     (CLK),
    .RST     (RST),
    .init    (crc_init),
    .en      (crc_en),
    .in_byte (in_data[7:0]),
    .crc     (crc_val)
  );

  // The last trailer byte is compared straight off the bus, so the verdict is
  // registered on the same edge that moves the FSM into CHECK.
  assign crc_ok  = ((crc_val ^ CRC_XOROUT) == {csm_q, in_data[7:0]});
  assign tmo_hit = (state_q != ST_HUNT) && !in_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    opt_d        = opt_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    csm_d        = csm_q;
    csm_cnt_d    = csm_cnt_q;
    o_opt_d      = o_opt_q;
    o_len_d      = o_len_q;
    o_data_d     = o_data_q;
    o_valid_d    = 1'b0;
    o_err_d      = 1'b0;
    o_err_code_d = o_err_code_q;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    tmo_d        = (state_q == ST_HUNT || in_valid) ? '0 : tmo_q + 1'b1;
    buf_wr       = buf_q;
    buf_wr[cnt_q*BYTE_SIZE +: BYTE_SIZE] = in_data;

    if (state_q != ST_HUNT && in_err) begin
      o_err_d      = 1'b1;
      o_err_code_d = ERR_LINE;
      state_d      = ST_HUNT;
    end else if (tmo_hit) begin
      o_err_d      = 1'b1;
      o_err_code_d = ERR_TIMEOUT;
      state_d      = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (in_valid && in_data == SYNC_BYTE) begin
            crc_init = 1'b1;
            state_d  = ST_OPT;
          end
        end
        ST_OPT: begin
          if (in_valid) begin
            opt_d   = in_data;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (in_valid) begin
            len_d = in_data;
            cnt_d = '0;
            if (in_data == '0 || in_data > MAX_LEN_B) begin
              o_err_d      = 1'b1;
              o_err_code_d = ERR_BAD_LEN;
              state_d      = ST_HUNT;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (in_valid) begin
            buf_d  = buf_wr;
            cnt_d  = cnt_q + 1'b1;
            crc_en = 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              csm_cnt_d = '0;
              if (CSM_EN) begin
                state_d = ST_CSM;
              end else begin
                o_opt_d   = opt_q;
                o_len_d   = len_q;
                o_data_d  = buf_wr;
                o_valid_d = 1'b1;
                state_d   = ST_CHECK;
              end
            end
          end
        end
        ST_CSM: begin
          if (in_valid) begin
            csm_d     = {csm_q[15:0], in_data[7:0]};
            csm_cnt_d = csm_cnt_q + 1'b1;
            if (csm_cnt_q == CSM_LAST) begin
              state_d = ST_CHECK;
              if (crc_ok) begin
                o_opt_d   = opt_q;
                o_len_d   = len_q;
                o_data_d  = buf_q;
                o_valid_d = 1'b1;
              end else begin
                o_err_d      = 1'b1;
                o_err_code_d = ERR_CRC;
              end
            end
          end
        end
        ST_CHECK: begin
          state_d = ST_HUNT;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_HUNT;
      opt_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      csm_q        <= '0;
      csm_cnt_q    <= '0;
      tmo_q        <= '0;
      o_opt_q      <= '0;
      o_len_q      <= '0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_err_q      <= 1'b0;
      o_err_code_q <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      opt_q        <= opt_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      csm_q        <= csm_d;
      csm_cnt_q    <= csm_cnt_d;
      tmo_q        <= tmo_d;
      o_opt_q      <= o_opt_d;
      o_len_q      <= o_len_d;
      o_data_q     <= o_data_d;
      o_valid_q    <= o_valid_d;
      o_err_q      <= o_err_d;
      o_err_code_q <= o_err_code_d;
    end
  end

  assign o_opt      = o_opt_q;
  assign o_len      = o_len_q;
  assign o_data     = o_data_q;
  assign o_valid    = o_valid_q;
  assign o_err      = o_err_q;
  assign o_err_code = o_err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames plus randomized frames scored
// against a frame-level model (parse, length rule, CRC-32 over payload).
module tb_uart_frame_rx;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 64;
  localparam logic [7:0] SYNC    = 8'h7E;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_err;
  logic [7:0]             o_opt;
  logic [7:0]             o_len;
  logic [MAX_LEN*8-1:0]   o_data;
  logic                   o_valid;
  logic                   o_err;
  logic [2:0]             o_err_code;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int         ev_code[$];
  int         ev_cyc[$];
  logic [7:0] frm[$];

  logic [7:0]           m_opt;
  logic [7:0]           m_len;
  logic [MAX_LEN*8-1:0] m_data;

  always #5 CLK = ~CLK;

  uart_frame_rx #(
    .BYTE_SIZE   (8),
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (SYNC),
    .CSM_EN      (1'b1),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_err     (in_err),
    .o_opt      (o_opt),
    .o_len      (o_len),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor: every output pulse is logged with the cycle it was seen in.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (o_valid || o_err) begin
      chk("pulse_exclusive", {127'd0, o_valid & o_err}, 128'd0);
      ev_code.push_back(o_err ? int'(o_err_code) : 0);
      ev_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] ref_crc(input logic [7:0] p[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      c = c ^ {24'd0, p[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_accept(input logic [7:0] opt, input logic [7:0] p[$]);
    m_opt  = opt;
    m_len  = 8'(p.size());
    m_data = '0;
    foreach (p[i]) m_data[i*8 +: 8] = p[i];
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(negedge CLK);
    in_valid = v;
    in_data  = d;
    in_err   = e;
  endtask

  // Sends frm; err_at >= 0 replaces byte err_at (and the rest) with an in_err cycle.
  task automatic send_frame(input int err_at, input int gap_max, output int last_c);
    last_c = cyc;
    for (int i = 0; i < frm.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) drive(1'b0, 8'h00, 1'b0);
      if (i == err_at) begin
        drive(1'b0, 8'h00, 1'b1);
        last_c = cyc;
        break;
      end
      drive(1'b1, frm[i], 1'b0);
      last_c = cyc;
    end
  endtask

  task automatic build_frame(input logic [7:0] opt, input logic [7:0] p[$], input bit corrupt);
    logic [31:0] c;
    c = ref_crc(p);
    if (corrupt) c = c ^ (32'd1 << $urandom_range(31, 0));
    frm.push_back(SYNC);
    frm.push_back(opt);
    frm.push_back(8'(p.size()));
    foreach (p[i]) frm.push_back(p[i]);
    frm.push_back(c[31:24]);
    frm.push_back(c[23:16]);
    frm.push_back(c[15:8]);
    frm.push_back(c[7:0]);
  endtask

  task automatic expect_outcome(input string tag, input int exp_n, input int exp_code,
                                input int exp_cyc, input int wait_n);
    repeat (wait_n) drive(1'b0, 8'h00, 1'b0);
    chk({tag, "_events"}, ev_code.size(), exp_n);
    if (ev_code.size() > 0) begin
      chk({tag, "_code"}, ev_code[0], exp_code);
      chk({tag, "_cycle"}, ev_cyc[0], exp_cyc);
    end
    chk({tag, "_opt"}, o_opt, m_opt);
    chk({tag, "_len"}, o_len, m_len);
    chk({tag, "_data"}, o_data, m_data);
    ev_code.delete();
    ev_cyc.delete();
  endtask

  task automatic random_frame();
    logic [7:0]  p[$];
    logic [7:0]  opt;
    logic [7:0]  b;
    int          len, nn, r, err_at, lc;
    bit          corrupt, bad_len;
    frm.delete();
    repeat ($urandom_range(2, 0)) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      frm.push_back(b);
    end
    nn  = frm.size();
    opt = 8'($urandom);
    r   = $urandom_range(9, 0);
    len = (r == 0) ? 0 : (r == 1) ? $urandom_range(255, MAX_LEN + 1) : $urandom_range(MAX_LEN, 1);
    bad_len = (len == 0 || len > MAX_LEN);
    corrupt = ($urandom_range(3, 0) == 0);
    if (bad_len) begin
      frm.push_back(SYNC);
      frm.push_back(opt);
      frm.push_back(8'(len));
    end else begin
      repeat (len) p.push_back(8'($urandom));
      build_frame(opt, p, corrupt);
    end
    err_at = ($urandom_range(4, 0) == 0) ? $urandom_range(frm.size() - 1, nn + 1) : -1;
    send_frame(err_at, 2, lc);
    if (err_at >= 0) begin
      expect_outcome("rnd_line", 1, 4, lc + 1, 6);
    end else if (bad_len) begin
      expect_outcome("rnd_len", 1, 1, lc + 1, 6);
    end else if (corrupt) begin
      expect_outcome("rnd_crc", 1, 2, lc + 1, 6);
    end else begin
      model_accept(opt, p);
      expect_outcome("rnd_good", 1, 0, lc + 1, 6);
    end
  endtask

  initial begin
    logic [7:0] p[$];
    string      s;
    int         lc;

    RST = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_err = 1'b0;
    m_opt = '0; m_len = '0; m_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_opt", o_opt, 8'h00);
    chk("rst_len", o_len, 8'h00);
    chk("rst_data", o_data, '0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_code", o_err_code, 3'd0);
    RST = 1'b0;
    ev_code.delete(); ev_cyc.delete();

    // Known-answer frame with leading noise; trailer bytes are the published check value.
    s = "123456789";
    for (int i = 0; i < s.len(); i++) p.push_back(s[i]);
    frm = {8'h00, 8'h55, 8'hFF, 8'h7E, 8'h01, 8'h09};
    foreach (p[i]) frm.push_back(p[i]);
    frm.push_back(8'hCB); frm.push_back(8'hF4); frm.push_back(8'h39); frm.push_back(8'h26);
    send_frame(-1, 0, lc);
    model_accept(8'h01, p);
    expect_outcome("good", 1, 0, lc + 1, 6);
    chk("good_ascii", o_data[71:0], 72'h39_3837_3635_3433_3231);
    chk("good_upper", o_data[127:72], '0);

    frm = {8'h7E, 8'h01, 8'h09};
    foreach (p[i]) frm.push_back(p[i]);
    frm.push_back(8'hCB); frm.push_back(8'hF4); frm.push_back(8'h39); frm.push_back(8'h27);
    send_frame(-1, 1, lc);
    expect_outcome("bad_crc", 1, 2, lc + 1, 6);

    frm = {8'h7E, 8'h05, 8'h00};
    send_frame(-1, 0, lc);
    expect_outcome("len_zero", 1, 1, lc + 1, 6);
    frm = {8'h7E, 8'h05, 8'h11};
    send_frame(-1, 0, lc);
    expect_outcome("len_big", 1, 1, lc + 1, 6);

    frm = {8'h7E, 8'h01, 8'h03, 8'hAA};
    send_frame(-1, 0, lc);
    expect_outcome("timeout", 1, 3, lc + 1 + TMO, TMO + 8);
    p = {8'h10, 8'h20, 8'h30};
    frm.delete();
    build_frame(8'h02, p, 1'b0);
    send_frame(-1, 1, lc);
    model_accept(8'h02, p);
    expect_outcome("after_tmo", 1, 0, lc + 1, 6);

    // A byte landing on the last idle cycle before the limit keeps the frame alive.
    p = {8'hAA, 8'hAA, 8'hBB};
    frm = {8'h7E, 8'h01, 8'h03, 8'hAA};
    send_frame(-1, 0, lc);
    repeat (TMO - 1) drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    frm.delete();
    build_frame(8'h01, p, 1'b0);
    frm = frm[5:$];
    send_frame(-1, 0, lc);
    model_accept(8'h01, p);
    expect_outcome("tmo_edge", 1, 0, lc + 1, 6);

    frm = {8'h7E, 8'h02, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(5, 0, lc);
    expect_outcome("line_err", 1, 4, lc + 1, 6);

    frm = {8'h7E, 8'h02, 8'h05, 8'h11};
    send_frame(-1, 0, lc);
    drive(1'b1, 8'h22, 1'b1);
    lc = cyc;
    expect_outcome("err_with_valid", 1, 4, lc + 1, 6);

    frm = {8'h7E, 8'h03, 8'h04, 8'h01, 8'h02};
    send_frame(-1, 0, lc);
    @(negedge CLK); in_valid = 1'b0; RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    m_opt = '0; m_len = '0; m_data = '0;
    expect_outcome("rst_abort", 0, 0, 0, 4);
    p = {8'hDE, 8'h7E, 8'hBE, 8'hEF, 8'h7E};
    frm.delete();
    build_frame(8'h5A, p, 1'b0);
    send_frame(-1, 0, lc);
    model_accept(8'h5A, p);
    expect_outcome("after_rst", 1, 0, lc + 1, 6);

    for (int k = 0; k < 150; k++) random_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
